// File: rtl/mix_memarb_pkg.sv
// Shared MIX definitions: word/address widths, arbiter state encoding and the
// memory-port request bundle used by the core and the loader.
package mix_memarb_pkg;

  localparam int MIX_WORD_W = 31;
  localparam int MIX_ADDR_W = 12;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [MIX_ADDR_W-1:0] addr;
    logic [MIX_WORD_W-1:0] wdata;
  } mem_req_t;

  localparam mem_req_t MEM_IDLE = '0;

endpackage

// File: rtl/mix_memarb_lock.sv
// Lock/age bookkeeping for the MIX memory arbiter: ARB/LOCK FSM, lock length
// limit with re-arm after a forced release, and io starvation ageing.
module mix_memarb_lock
  import mix_memarb_pkg::*;
#(
  parameter int AGE_MAX  = 8,
  parameter int LOCK_MAX = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic hold_i,
  input  logic io_req_i,
  input  logic io_lock_i,
  input  logic io_gnt_i,
  output logic in_lock_o,
  output logic age_top_o
);

  localparam int AGE_W  = $clog2(AGE_MAX + 1);
  localparam int LOCK_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_e        state_q;
  logic [AGE_W-1:0]  age_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic              armed_q;
  logic              lock_last;

  assign lock_last = (lock_cnt_q == LOCK_W'(LOCK_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      age_cnt_q  <= '0;
      lock_cnt_q <= '0;
      armed_q    <= 1'b1;
    end else begin
      if (!io_req_i || io_gnt_i)
        age_cnt_q <= '0;
      else if (!hold_i && age_cnt_q != AGE_W'(AGE_MAX))
        age_cnt_q <= age_cnt_q + 1'b1;

      if (!io_lock_i)
        armed_q <= 1'b1;

      case (state_q)
        ARB: begin
          if (io_gnt_i && io_lock_i && armed_q)
            state_q <= LOCK;
        end
        LOCK: begin
          // hold freezes the lock in place; the counter saturates so a forced
          // release still fires as soon as hold drops
          if (!hold_i && (!io_lock_i || lock_last)) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
            if (io_lock_i)
              armed_q <= 1'b0;
          end else if (!lock_last) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign in_lock_o = (state_q == LOCK);
  assign age_top_o = (age_cnt_q == AGE_W'(AGE_MAX));

endmodule

// File: rtl/mix_memarb.sv
// MIX memory arbiter: fetch, operand and loader/IO ports share one 4096x31
// synchronous memory; grants are combinational, read-valids registered.
module mix_memarb
  import mix_memarb_pkg::*;
#(
  parameter int AGE_MAX  = 8,
  parameter int LOCK_MAX = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  f_req,
  input  logic [MIX_ADDR_W-1:0] f_addr,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [MIX_ADDR_W-1:0] d_addr,
  input  logic [MIX_WORD_W-1:0] d_wdata,
  input  logic                  io_req,
  input  logic                  io_we,
  input  logic                  io_lock,
  input  logic [MIX_ADDR_W-1:0] io_addr,
  input  logic [MIX_WORD_W-1:0] io_wdata,
  output logic                  f_gnt,
  output logic                  d_gnt,
  output logic                  io_gnt,
  output logic                  f_rvalid,
  output logic                  d_rvalid,
  output logic                  io_rvalid,
  output logic [MIX_WORD_W-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MIX_ADDR_W-1:0] mem_addr,
  output logic [MIX_WORD_W-1:0] mem_wdata,
  input  logic [MIX_WORD_W-1:0] mem_rdata
);

  logic     in_lock, age_top;
  logic     f_rvalid_q, d_rvalid_q, io_rvalid_q;
  mem_req_t mreq;

  mix_memarb_lock #(
    .AGE_MAX (AGE_MAX),
    .LOCK_MAX(LOCK_MAX)
  ) u_lock (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (hold),
    .io_req_i (io_req),
    .io_lock_i(io_lock),
    .io_gnt_i (io_gnt),
    .in_lock_o(in_lock),
    .age_top_o(age_top)
  );

  // Normal order d > f > io; a starved io jumps to the front; a lock owns the bus.
  always_comb begin
    f_gnt  = 1'b0;
    d_gnt  = 1'b0;
    io_gnt = 1'b0;
    if (!reset && !hold) begin
      if (in_lock)              io_gnt = io_req;
      else if (age_top && io_req) io_gnt = 1'b1;
      else if (d_req)           d_gnt  = 1'b1;
      else if (f_req)           f_gnt  = 1'b1;
      else if (io_req)          io_gnt = 1'b1;
    end
  end

  always_comb begin
    mreq = MEM_IDLE;
    if (d_gnt)       mreq = '{en: 1'b1, we: d_we,  addr: d_addr,  wdata: d_wdata};
    else if (f_gnt)  mreq = '{en: 1'b1, we: 1'b0,  addr: f_addr,  wdata: '0};
    else if (io_gnt) mreq = '{en: 1'b1, we: io_we, addr: io_addr, wdata: io_wdata};
  end

  assign mem_en    = mreq.en;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      io_rvalid_q <= 1'b0;
    end else begin
      f_rvalid_q  <= f_gnt;
      d_rvalid_q  <= d_gnt && !d_we;
      io_rvalid_q <= io_gnt && !io_we;
    end
  end

  assign f_rvalid  = f_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign io_rvalid = io_rvalid_q;
  assign rdata     = mem_rdata;

endmodule
